control_unit: RTL

Hardwired control sequencer for the 32-bit CPU datapath. Each clock cycle, it steps a fetch/decode/execute state machine and drives the datapath's register-transfer control strobes: PCout, MARin, Gra/Grb/Grc, Rin/Rout, ALU op selects, and the others. It sits directly upstream of DataPath, consumes the latched instruction register, and replaces hand-sequenced strobe generation for the supported instruction subset.

---
 rtl/cpu_pkg.sv | 87 ++++++++
 rtl/ctrl_decode.sv | 134 +++++++++++++
 rtl/control_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the hardwired control sequencer.
//   - opcode values (ir[31:27])
//   - state encoding; the numeric codes are visible on present_state
//   - ctrl_t, the packed vector of every strobe the sequencer drives
//   - op_class(), which groups opcodes by the step sequence they follow
package cpu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd15
  } state_t;

  // Instruction groups that share an execute sequence.
  typedef enum logic [2:0] {
    CLS_NOP,   // nop and every undefined opcode
    CLS_ALU,   // add/sub/and/or
    CLS_IMM,   // addi/ldi
    CLS_LD,
    CLS_ST,
    CLS_JR,
    CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic run;
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mar_clear;
    logic mdr_in;
    logic mdr_out;
    logic md_read;
    logic read;
    logic write;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zlow_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic csign_out;
    logic alu_add;
    logic alu_sub;
    logic alu_and;
    logic alu_or;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [OPC_W-1:0] op);
    case (op)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: op_class = CLS_ALU;
      OPC_ADDI, OPC_LDI:                 op_class = CLS_IMM;
      OPC_LD:                            op_class = CLS_LD;
      OPC_ST:                            op_class = CLS_ST;
      OPC_JR:                            op_class = CLS_JR;
      OPC_HALT:                          op_class = CLS_HALT;
      default:                           op_class = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational map from (state, opcode) to the full
// control vector. Everything not named for a state stays 0.
//   state  in   current sequencer state
//   opcode in   ir[31:27]; only meaningful from T3 onward
//   ctrl   out  strobes plus run
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);

  op_class_t cls;
  assign cls = op_class(opcode);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_RESET: ctrl.mar_clear = 1'b1;
      ST_T0: begin
        ctrl.run     = 1'b1;
        ctrl.pc_out  = 1'b1;
        ctrl.mar_in  = 1'b1;
        ctrl.inc_pc  = 1'b1;
        ctrl.zlow_in = 1'b1;
      end
      ST_T1: begin
        ctrl.run      = 1'b1;
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.md_read  = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      ST_T2: begin
        ctrl.run     = 1'b1;
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      ST_T3: begin
        ctrl.run = 1'b1;
        case (cls)
          CLS_ALU: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          // BAout rather than Rout: R0 reads as zero here, so ldi rb=R0 loads C.
          CLS_IMM, CLS_LD, CLS_ST: begin
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          CLS_JR: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        ctrl.run = 1'b1;
        case (cls)
          CLS_ALU: begin
            ctrl.grc     = 1'b1;
            ctrl.r_out   = 1'b1;
            ctrl.zlow_in = 1'b1;
            ctrl.alu_add = (opcode == OPC_ADD);
            ctrl.alu_sub = (opcode == OPC_SUB);
            ctrl.alu_and = (opcode == OPC_AND);
            ctrl.alu_or  = (opcode == OPC_OR);
          end
          // Effective address / immediate sum: Y + sign-extended C.
          CLS_IMM, CLS_LD, CLS_ST: begin
            ctrl.csign_out = 1'b1;
            ctrl.alu_add   = 1'b1;
            ctrl.zlow_in   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        ctrl.run = 1'b1;
        case (cls)
          CLS_ALU, CLS_IMM: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.zlow_out = 1'b1;
            ctrl.mar_in   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        ctrl.run = 1'b1;
        case (cls)
          CLS_LD: begin
            ctrl.read    = 1'b1;
            ctrl.md_read = 1'b1;
            ctrl.mdr_in  = 1'b1;
          end
          // md_read stays 0 so the MDR input mux takes the bus, not memory.
          CLS_ST: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        ctrl.run = 1'b1;
        case (cls)
          CLS_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          CLS_ST:  ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;  // HALT: everything low, run low
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for the 32-bit
// datapath. Moore machine; strobes decode from present state and ir[31:27].
//   clock          in   rising-edge clock
//   clear          in   asynchronous active-low reset
//   ir             in   instruction register (valid from T3 on)
//   stop           in   level; sampled only in the last step of an
//                       instruction, where it redirects the next state to HALT
//   run            out  high in T0..T7
//   present_state  out  state code (RESET=0, T0..T7=1..8, HALT=15)
//   remaining outs      datapath / register-select / ALU strobes
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        run,
  output logic [3:0]  present_state,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MAR_clear,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MD_read,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Csignout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR
);

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode;
  op_class_t      cls;
  logic           last_step;
  ctrl_t          ctrl;
  logic           unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign cls       = op_class(opcode);
  assign unused_ir = ^ir[31-OPW:0];

  // Final step of each instruction group; the only place stop is honoured.
  always_comb begin
    last_step = 1'b0;
    case (state_q)
      ST_T3:   last_step = (cls == CLS_NOP) || (cls == CLS_JR);
      ST_T5:   last_step = (cls == CLS_ALU) || (cls == CLS_IMM);
      ST_T7:   last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_T3 && cls == CLS_HALT) begin
      state_d = ST_HALT;
    end else if (last_step) begin
      state_d = stop ? ST_HALT : ST_T0;
    end else begin
      case (state_q)
        ST_RESET: state_d = ST_T0;
        ST_T0:    state_d = ST_T1;
        ST_T1:    state_d = ST_T2;
        ST_T2:    state_d = ST_T3;
        ST_T3:    state_d = ST_T4;
        ST_T4:    state_d = ST_T5;
        ST_T5:    state_d = ST_T6;
        ST_T6:    state_d = ST_T7;
        default:  state_d = state_q;  // HALT holds until clear
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Outputs decode straight from state_q, so clear forces the reset strobe
  // pattern immediately without waiting for an edge.
  ctrl_decode #(.OPW(OPW)) u_decode (
    .state  (state_q),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign present_state = state_q;
  assign run       = ctrl.run;
  assign PCout     = ctrl.pc_out;
  assign PCin      = ctrl.pc_in;
  assign IncPC     = ctrl.inc_pc;
  assign MARin     = ctrl.mar_in;
  assign MAR_clear = ctrl.mar_clear;
  assign MDRin     = ctrl.mdr_in;
  assign MDRout    = ctrl.mdr_out;
  assign MD_read   = ctrl.md_read;
  assign Read      = ctrl.read;
  assign Write     = ctrl.write;
  assign IRin      = ctrl.ir_in;
  assign Yin       = ctrl.y_in;
  assign Zlowin    = ctrl.zlow_in;
  assign Zlowout   = ctrl.zlow_out;
  assign Gra       = ctrl.gra;
  assign Grb       = ctrl.grb;
  assign Grc       = ctrl.grc;
  assign Rin       = ctrl.r_in;
  assign Rout      = ctrl.r_out;
  assign BAout     = ctrl.ba_out;
  assign Csignout  = ctrl.csign_out;
  assign ADD       = ctrl.alu_add;
  assign SUB       = ctrl.alu_sub;
  assign AND       = ctrl.alu_and;
  assign OR        = ctrl.alu_or;

endmodule
